// File: rtl/wb_burst_master_if.sv
// Wishbone bus bundle for wb_burst_master.
// master modport: drives cyc/stb/we/adr/dat/sel/tags, samples dat_i and the
//                 ack/err/rty responses.
// slave modport:  the mirror image, for a slave model or a real slave.
interface wb_burst_master_if #(
    parameter int TAGSIZE = 2
);
    logic               wb_cyc_o;
    logic               wb_stb_o;
    logic               wb_we_o;
    logic [31:0]        wb_adr_o;
    logic [31:0]        wb_dat_o;
    logic [3:0]         wb_sel_o;
    logic [TAGSIZE-1:0] wb_tgd_o;
    logic [TAGSIZE-1:0] wb_tga_o;
    logic [TAGSIZE-1:0] wb_tgc_o;
    logic [31:0]        wb_dat_i;
    logic               wb_ack_i;
    logic               wb_err_i;
    logic               wb_rty_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
               wb_tgd_o, wb_tga_o, wb_tgc_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
               wb_tgd_o, wb_tga_o, wb_tgc_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone burst master: accepts one burst request from a core
// (valid/ready handshake), issues len_i+1 incrementing word beats on the bus,
// retries on rty with a one-cycle backoff, and aborts on err, on too many
// retries, or when a beat gets no response within TIMEOUT strobe cycles.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i / ready_o   request handshake
//   addr_i, we_i, sel_i, len_i   burst parameters, captured on accept
//   data_i              write data of the current beat (combinational to bus)
//   data_o, beat_o      read data and per-beat acknowledge pulse
//   done_o, err_o       end-of-burst pulse, err_o marks an aborted burst
//   wb                  Wishbone master bus (wb_burst_master_if.master)
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | ready for a request
// BUS     | cyc/stb asserted, waiting for a slave response
// BACKOFF | one cycle with stb low after rty, cyc held
// DONE    | one-cycle done_o pulse, err_o gives the outcome
module wb_burst_master #(
    parameter int TAGSIZE   = 2,
    parameter int RETRY_MAX = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [3:0]  len_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        beat_o,
    output logic        done_o,
    output logic        err_o,
    wb_burst_master_if.master wb
);
    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, BACKOFF, DONE} state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q;
    logic           we_q;
    logic [3:0]     sel_q;
    logic [3:0]     len_q;
    logic [3:0]     beat_q;
    logic [RW-1:0]  retry_q;
    logic [TW-1:0]  tmo_q;
    logic           err_q;

    logic load, adv, retry_inc, tmo_inc, abort;

    assign wb.wb_tgd_o = '0;
    assign wb.wb_tga_o = '0;
    assign wb.wb_tgc_o = '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ready_o     = 1'b0;
        beat_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        data_o      = '0;
        wb.wb_cyc_o = 1'b0;
        wb.wb_stb_o = 1'b0;
        wb.wb_we_o  = 1'b0;
        wb.wb_adr_o = '0;
        wb.wb_dat_o = '0;
        wb.wb_sel_o = '0;
        load        = 1'b0;
        adv         = 1'b0;
        retry_inc   = 1'b0;
        tmo_inc     = 1'b0;
        abort       = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    load    = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                wb.wb_cyc_o = 1'b1;
                wb.wb_stb_o = 1'b1;
                wb.wb_we_o  = we_q;
                wb.wb_adr_o = addr_q;
                wb.wb_sel_o = sel_q;
                wb.wb_dat_o = we_q ? data_i : 32'h0;
                // err beats ack beats rty when several arrive together
                if (wb.wb_err_i) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end else if (wb.wb_ack_i) begin
                    beat_o = 1'b1;
                    data_o = wb.wb_dat_i;
                    adv    = 1'b1;
                    if (beat_q == len_q) state_d = DONE;
                end else if (wb.wb_rty_i) begin
                    if (retry_q == RW'(RETRY_MAX)) begin
                        abort   = 1'b1;
                        state_d = DONE;
                    end else begin
                        retry_inc = 1'b1;
                        state_d   = BACKOFF;
                    end
                end else begin
                    // this is the TIMEOUT-th silent strobe cycle
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        abort   = 1'b1;
                        state_d = DONE;
                    end else begin
                        tmo_inc = 1'b1;
                    end
                end
            end
            BACKOFF: begin
                wb.wb_cyc_o = 1'b1;
                wb.wb_we_o  = we_q;
                wb.wb_adr_o = addr_q;
                wb.wb_sel_o = sel_q;
                state_d     = BUS;
            end
            DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            retry_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (load) begin
                addr_q  <= addr_i;
                we_q    <= we_i;
                sel_q   <= sel_i;
                len_q   <= len_i;
                beat_q  <= '0;
                retry_q <= '0;
                tmo_q   <= '0;
                err_q   <= 1'b0;
            end
            if (adv) begin
                addr_q  <= addr_q + 32'd4;
                beat_q  <= beat_q + 4'd1;
                retry_q <= '0;
                tmo_q   <= '0;
            end
            if (retry_inc) retry_q <= retry_q + 1'b1;
            if (tmo_inc)   tmo_q   <= tmo_q + 1'b1;
            if (abort)     err_q   <= 1'b1;
        end
    end
endmodule
